// File: rtl/spi_host_tx_unpacker.sv
// TX window word FIFO feeding the byte-serial shift engine: buffers {be, data}
// words and issues only the enabled byte lanes, one per handshake.
module spi_host_tx_unpacker #(
    parameter int Depth     = 16,
    parameter bit ByteOrder = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic [31:0]              tx_data_i,
    input  logic [3:0]               tx_be_i,
    input  logic                     tx_valid_i,
    output logic                     tx_ready_o,
    output logic [7:0]               byte_o,
    output logic                     byte_valid_o,
    input  logic                     byte_ready_i,
    output logic [$clog2(Depth):0]   depth_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(Depth);

    logic [35:0]   mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    cons_q, cons_d;
    logic [AW:0]   depth_q, depth_d;
    logic          overflow_q, overflow_d;

    logic [35:0]   head;
    logic [3:0]    rem;
    logic [3:0]    lane_oh;
    logic [1:0]    lane;
    logic          empty, full, hs, pop, push;

    assign head    = mem_q[rd_ptr_q];
    assign empty   = (depth_q == '0);
    assign full    = (depth_q == (AW+1)'(Depth));
    assign rem     = head[35:32] & ~cons_q;

    // Pick the next lane to issue from the lanes not yet consumed.
    always_comb begin
        lane = 2'd0;
        if (ByteOrder == 1'b0) begin
            for (int i = 3; i >= 0; i--) if (rem[i]) lane = 2'(i);
        end else begin
            for (int i = 0; i < 4; i++) if (rem[i]) lane = 2'(i);
        end
    end

    assign lane_oh = 4'b0001 << lane;
    assign hs      = !empty && byte_ready_i && !clear_i;
    assign pop     = hs && ((rem & ~lane_oh) == 4'b0000);
    assign push    = tx_valid_i && !full && !clear_i && (tx_be_i != 4'b0000);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cons_d     = cons_q;
        depth_d    = depth_q;
        overflow_d = tx_valid_i && full && !clear_i && (tx_be_i != 4'b0000);
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cons_d   = 4'b0000;
            depth_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                cons_d   = 4'b0000;
            end else if (hs) begin
                cons_d = cons_q | lane_oh;
            end
            depth_d = depth_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cons_q     <= 4'b0000;
            depth_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cons_q     <= cons_d;
            depth_q    <= depth_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: an entry is only read once depth covers it.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {tx_be_i, tx_data_i};
    end

    assign tx_ready_o   = !full;
    assign full_o       = full;
    assign empty_o      = empty;
    assign depth_o      = depth_q;
    assign overflow_o   = overflow_q;
    assign byte_valid_o = !empty;
    assign byte_o       = empty ? 8'h00 : head[{lane, 3'b000} +: 8];

endmodule

// File: tb/tb_spi_host_tx_unpacker.sv
// Directed bench for spi_host_tx_unpacker with a byte scoreboard; a second
// instance with reversed byte order is checked on the first word only.
module tb_spi_host_tx_unpacker;

    localparam int Depth = 16;
    localparam int DW    = $clog2(Depth) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          clear_i = 1'b0;
    logic [31:0]   tx_data_i = '0;
    logic [3:0]    tx_be_i = '0;
    logic          tx_valid_i = 1'b0;
    logic          byte_ready_i = 1'b0;
    logic          tx_ready_o, byte_valid_o, empty_o, full_o, overflow_o;
    logic [7:0]    byte_o;
    logic [DW-1:0] depth_o;

    logic          r_tx_ready, r_valid, r_empty, r_full, r_ovf;
    logic [7:0]    r_byte;
    logic [DW-1:0] r_depth;

    int tests = 0;
    int fails = 0;
    logic [7:0] sb [$];

    spi_host_tx_unpacker #(.Depth(Depth), .ByteOrder(1'b0)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .tx_data_i(tx_data_i), .tx_be_i(tx_be_i), .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
        .byte_ready_i(byte_ready_i), .depth_o(depth_o), .empty_o(empty_o),
        .full_o(full_o), .overflow_o(overflow_o)
    );

    spi_host_tx_unpacker #(.Depth(Depth), .ByteOrder(1'b1)) u_dut_rev (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .tx_data_i(tx_data_i), .tx_be_i(tx_be_i), .tx_valid_i(tx_valid_i),
        .tx_ready_o(r_tx_ready), .byte_o(r_byte), .byte_valid_o(r_valid),
        .byte_ready_i(byte_ready_i), .depth_o(r_depth), .empty_o(r_empty),
        .full_o(r_full), .overflow_o(r_ovf)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic void push_word(input logic [31:0] d, input logic [3:0] be);
        for (int i = 0; i < 4; i++) if (be[i]) sb.push_back(d[8*i +: 8]);
    endfunction

    task automatic wr(input logic [31:0] d, input logic [3:0] be, input bit store);
        tx_data_i  = d;
        tx_be_i    = be;
        tx_valid_i = 1'b1;
        if (store) push_word(d, be);
        tick();
        tx_valid_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        byte_ready_i = 1'b1;
        while (!empty_o && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_budget", 32'(n < budget), 32'd1);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    // Byte scoreboard: every handshake must match the next expected byte.
    always @(negedge clk_i) begin
        if (!rst_i && !clear_i && byte_valid_o && byte_ready_i) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_unexpected: observed %0h expected none", byte_o);
            end else begin
                chk("byte", 32'(byte_o), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] rev_exp [4];
        rev_exp[0] = 8'h44; rev_exp[1] = 8'h33; rev_exp[2] = 8'h22; rev_exp[3] = 8'h11;

        // Reset values
        #1;
        chk("rst_async_valid", 32'(byte_valid_o), 32'd0);
        tick(); tick();
        chk("rst_tx_ready", 32'(tx_ready_o), 32'd1);
        chk("rst_byte", 32'(byte_o), 32'h00);
        chk("rst_depth", 32'(depth_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Full word, both byte orders, no bubbles
        byte_ready_i = 1'b1;
        wr(32'h44332211, 4'hF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("w1_valid", 32'(byte_valid_o), 32'd1);
            chk("w1_depth", 32'(depth_o), 32'd1);
            chk("w1_rev_byte", 32'(r_byte), 32'(rev_exp[i]));
            tick();
        end
        chk("w1_depth_after", 32'(depth_o), 32'd0);
        chk("w1_empty_after", 32'(empty_o), 32'd1);

        // Sparse enables across a word boundary
        wr(32'hDDCCBBAA, 4'hA, 1'b1);
        chk("w2_byte0", 32'(byte_o), 32'hBB);
        wr(32'h000000EE, 4'h1, 1'b1);
        chk("w2_depth", 32'(depth_o), 32'd2);
        chk("w2_byte1", 32'(byte_o), 32'hDD);
        tick();
        chk("w2_byte2", 32'(byte_o), 32'hEE);
        chk("w2_valid2", 32'(byte_valid_o), 32'd1);
        tick();
        chk("w2_empty", 32'(empty_o), 32'd1);

        // Zero enables: silently discarded
        wr(32'h12345678, 4'h0, 1'b0);
        chk("be0_depth", 32'(depth_o), 32'd0);
        chk("be0_valid", 32'(byte_valid_o), 32'd0);
        chk("be0_ovf", 32'(overflow_o), 32'd0);

        // Fill, overflow, hold, single-step
        byte_ready_i = 1'b0;
        for (int i = 0; i < Depth; i++)
            wr({8'(i + 48), 8'(i + 32), 8'(i + 16), 8'(i)}, 4'((i % 15) + 1), 1'b1);
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_tx_ready", 32'(tx_ready_o), 32'd0);
        chk("fill_depth", 32'(depth_o), 32'(Depth));
        chk("fill_ovf_quiet", 32'(overflow_o), 32'd0);
        wr(32'hFFFFFFFF, 4'hF, 1'b0);
        chk("ovf_pulse", 32'(overflow_o), 32'd1);
        tick();
        chk("ovf_once", 32'(overflow_o), 32'd0);
        chk("ovf_depth", 32'(depth_o), 32'(Depth));
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(byte_valid_o), 32'd1);
            chk("hold_byte", 32'(byte_o), 32'(sb[0]));
            tick();
        end
        byte_ready_i = 1'b1;
        tick();
        byte_ready_i = 1'b0;
        chk("step_byte", 32'(byte_o), 32'(sb[0]));
        tick();
        chk("step_hold", 32'(byte_o), 32'(sb[0]));
        drain(200);

        // Simultaneous push and pop at depth 1, across pointer wrap
        byte_ready_i = 1'b1;
        for (int k = 0; k < 3 * Depth; k++) begin
            wr(32'(k + 8'h80), 4'h1, 1'b1);
            chk("d1_depth", 32'(depth_o), 32'd1);
        end
        tick();
        chk("d1_empty", 32'(depth_o), 32'd0);

        // Simultaneous push and pop at depth Depth-1
        byte_ready_i = 1'b0;
        for (int k = 0; k < Depth - 1; k++) wr(32'(k) << 24, 4'h8, 1'b1);
        byte_ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wr(32'(k + 8'h40) << 16, 4'h4, 1'b1);
            chk("dm1_depth", 32'(depth_o), 32'(Depth - 1));
        end
        drain(200);

        // Clear mid-word with a concurrent write
        wr(32'h44332211, 4'hF, 1'b0);
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        tick(); tick();
        chk("clr_pre_byte", 32'(byte_o), 32'h33);
        clear_i    = 1'b1;
        tx_valid_i = 1'b1;
        tx_data_i  = 32'hCAFEF00D;
        tx_be_i    = 4'hF;
        tick();
        clear_i    = 1'b0;
        tx_valid_i = 1'b0;
        chk("clr_empty", 32'(empty_o), 32'd1);
        chk("clr_valid", 32'(byte_valid_o), 32'd0);
        chk("clr_ovf", 32'(overflow_o), 32'd0);
        chk("clr_sb", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-burst
        wr(32'h0A0B0C0D, 4'hF, 1'b1);
        wr(32'h01020304, 4'hF, 1'b1);
        #3 rst_i = 1'b1;
        #1;
        chk("arst_valid", 32'(byte_valid_o), 32'd0);
        chk("arst_byte", 32'(byte_o), 32'h00);
        chk("arst_depth", 32'(depth_o), 32'd0);
        chk("arst_empty", 32'(empty_o), 32'd1);
        chk("arst_tx_ready", 32'(tx_ready_o), 32'd1);
        chk("arst_full", 32'(full_o), 32'd0);
        chk("arst_ovf", 32'(overflow_o), 32'd0);
        sb.delete();
        tick(); tick();
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", 32'(byte_valid_o), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_host_tx_unpacker.md
# spi_host_tx_unpacker

TX data path stage between the SPI host TX FIFO window and the shift engine. It takes the 32-bit words and byte enables written through the TX window and buffers them in a word FIFO. It then issues only the enabled bytes, one per handshake, to the byte-serial shift engine. The window has no backpressure, so words that arrive while the FIFO is full are dropped and reported.

## Interface
- Depth, 16, number of word entries; power of two, >= 2
- ByteOrder, 0, 0 = byte lane 0 issued first (little-endian); 1 = lane 3 issued first
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; asynchronous, active-high
- clear_i  in  1  synchronous flush of all stored words and partial-word state
- tx_data_i  in  32  write data from the TX window
- tx_be_i  in  4  byte enables from the TX window
- tx_valid_i  in  1  single-cycle write strobe from the TX window
- tx_ready_o  out  1  FIFO can accept a word this cycle (= !full_o)
- byte_o  out  8  current byte to the shift engine
- byte_valid_o  out  1  byte_o is valid
- byte_ready_i  in  1  shift engine consumes byte_o when byte_valid_o is also high
- depth_o  out  $clog2(Depth)+1  number of stored words, including a partially issued head word
- empty_o  out  1  depth_o == 0
- full_o  out  1  depth_o == Depth
- overflow_o  out  1  one-cycle pulse: a write was dropped because the FIFO was full

## Operation
- Storage: Depth entries of {be[3:0], data[31:0]}.
  - Write pointer and read pointer are $clog2(Depth) bits wide and wrap naturally.
  - depth_o is a separate counter.
- Write acceptance:
  - A word is accepted when tx_valid_i && !full_o && !clear_i && tx_be_i != 0.
  - A word with tx_be_i == 0 is discarded silently. It is not stored, not counted and does not cause overflow.
- Overflow:
  - tx_valid_i && full_o && tx_be_i != 0 && !clear_i drops the word.
  - overflow_o pulses high on the next cycle.
  - Full is judged on the registered depth. A pop of the last byte in the same cycle does not make room.
- Head word issue:
  - A consumed mask cons[3:0] is kept for the head entry.
  - The remaining lanes are rem = be & ~cons.
  - The selected lane is the lowest set bit of rem (ByteOrder=0) or the highest set bit (ByteOrder=1).
  - byte_o = data[8*lane +: 8].
  - byte_valid_o = !empty_o.
- Handshake (byte_valid_o && byte_ready_i):
  - If other bits of rem remain, the selected lane's bit is set in cons.
  - If the selected lane was the last one, the entry is popped: read pointer +1, cons <= 0, depth -1.
- Simultaneous accepted write and pop: depth_o is unchanged and both pointers advance.
- clear_i:
  - Pointers, cons and depth are set to 0.
  - A write or handshake in the same cycle is ignored (clear wins).
  - overflow_o is not raised for a write in the clear cycle.
- When byte_valid_o is 0, byte_o is driven to 0x00.

## Timing
- Reset (async assert, sync release by the surrounding design):
  - Pointers, cons and depth are 0.
  - tx_ready_o=1, byte_valid_o=0, byte_o=0x00, depth_o=0, empty_o=1, full_o=0, overflow_o=0.
- Write to byte latency:
  - A word accepted at edge N makes byte_valid_o high after edge N, in cycle N+1.
  - There is no combinational path from tx_* to byte_*.
- byte_o, byte_valid_o, empty_o, full_o and tx_ready_o are decoded only from registered state.
  - byte_ready_i has no combinational path to any output.
- Throughput: one byte per cycle while byte_ready_i is held high. Crossing word boundaries adds no bubbles.
- A word with a single enabled lane pops in the same cycle its byte is handshaked.
- While byte_ready_i is low, byte_o and byte_valid_o hold stable (valid is never withdrawn except by clear_i or reset).
- depth_o, full_o and empty_o update on the edge after the causing event.
- Reset mid-word: the partial head and all stored words are lost. A byte is never issued twice after release.

## Test plan
- Reset, then write 0x44332211 with be=0xF, holding byte_ready_i=1.
  - ByteOrder=0: bytes 0x11, 0x22, 0x33, 0x44 on four consecutive cycles starting 1 cycle after the write.
  - depth_o goes 1 then 0.
  - ByteOrder=1: bytes 0x44, 0x33, 0x22, 0x11.
- Write 0xDDCCBBAA with be=0xA, then 0x000000EE with be=0x1, with byte_ready_i=1.
  - Bytes 0xBB, 0xDD, 0xEE with no bubble.
  - Write 0x12345678 with be=0x0: no byte issued, depth_o stays 0.
- With byte_ready_i=0, write Depth words.
  - full_o=1 and tx_ready_o=0.
  - A further write pulses overflow_o exactly once, one cycle later.
  - Draining then shows only the first Depth words, in order.
- With byte_ready_i=0, hold byte_valid_o for 10 cycles.
  - byte_o stays stable.
  - Pulse byte_ready_i for 1 cycle: exactly one byte advances.
- Stress simultaneous write and pop at depth 1 and depth Depth-1.
  - depth_o is unchanged.
  - Data order holds across pointer wrap, after more than 2*Depth words.
- Assert clear_i mid-word (after 2 of 4 bytes) in the same cycle as a tx_valid_i write.
  - Next cycle: empty_o=1, byte_valid_o=0, overflow_o=0.
  - Then assert rst_i asynchronously mid-burst: all outputs reach their reset values without waiting for a clock edge.
